// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    FULL,
    OVER
  } spi_state_e;

  localparam logic SPI_WR = 1'b1;
  localparam logic SPI_RD = 1'b0;

  function automatic int unsigned frame_bits(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an external controller and the peripheral.
interface spi_regfile_peripheral_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin with registered edge pulses.
module spi_pin_sync #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0,
  parameter bit          EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              rise_q;
  logic              fall_q;

  // Edges come from the last two stages, so they line up with level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      rise_q <= EDGES &  sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall_q <= EDGES & ~sync_q[STAGES-2] &  sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral with an oversampled read/write register bank.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int unsigned FRAME = frame_bits(ADDR_W, DATA_W);
  localparam int unsigned CNT_W = $clog2(FRAME + 1);
  localparam int unsigned CMD_W = 1 + ADDR_W;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_ncs_sync (
    .clk(clk), .rst_n(rst_n), .d(spi.ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_copi_sync (
    .clk(clk), .rst_n(rst_n), .d(spi.copi),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  spi_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CMD_W-1:0]         cmd_q, cmd_d, cmd_shift;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [DATA_W-1:0]        tx_q, tx_d, rd_val;
  logic                     cipo_q, cipo_d;
  logic                     oe_q, oe_d;
  logic [NUM_REGS-1:0]      strobe_q, strobe_d;
  logic                     err_q, err_d;
  logic [DATA_W-1:0]        bank_q [NUM_REGS];
  logic [DATA_W-1:0]        bank_d [NUM_REGS];
  logic [SYNC_STAGES-1:0]   flush_q, flush_d;
  logic                     armed_q, armed_d;

  assign cmd_shift = {cmd_q[CMD_W-2:0], copi_lvl};

  // Read source for the address completing on this sample; out of range reads zero.
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (cmd_shift[ADDR_W-1:0] == ADDR_W'(k)) rd_val = bank_q[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    tx_d     = tx_q;
    cipo_d   = cipo_q;
    oe_d     = ~ncs_lvl;
    strobe_d = '0;
    err_d    = 1'b0;
    bank_d   = bank_q;
    // A select already low when reset lifts is ignored until ncs is seen high.
    flush_d  = {flush_q[SYNC_STAGES-2:0], 1'b1};
    armed_d  = armed_q | (flush_q[SYNC_STAGES-1] & ncs_lvl);

    if (ncs_rise) begin
      state_d = IDLE;
      cipo_d  = 1'b0;
      case (state_q)
        FULL: begin
          if (cmd_q[CMD_W-1] == SPI_WR) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (cmd_q[ADDR_W-1:0] == ADDR_W'(k)) begin
                bank_d[k]   = data_q;
                strobe_d[k] = 1'b1;
              end
            end
          end
        end
        CMD, DATA: err_d = (cnt_q != '0);
        OVER:      err_d = 1'b1;
        default:   ;
      endcase
    end else if (ncs_fall && armed_q) begin
      state_d = CMD;
      cnt_d   = '0;
      cmd_d   = '0;
      data_d  = '0;
      tx_d    = '0;
      cipo_d  = 1'b0;
    end else if (sclk_rise) begin
      case (state_q)
        CMD: begin
          cmd_d = cmd_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W)) begin
            state_d = DATA;
            if (cmd_shift[CMD_W-1] == SPI_RD) begin
              tx_d   = rd_val;
              cipo_d = rd_val[DATA_W-1];
            end
          end
        end
        DATA: begin
          data_d = {data_q[DATA_W-2:0], copi_lvl};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME - 1)) state_d = FULL;
        end
        FULL: begin
          state_d = OVER;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end else if (sclk_fall && (state_q inside {DATA, FULL, OVER}) &&
                 (cmd_q[CMD_W-1] == SPI_RD) && (cnt_q != CNT_W'(CMD_W))) begin
      // The fall right after the load keeps the MSB; later falls advance.
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      cipo_d = tx_q[DATA_W-2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      tx_q     <= '0;
      cipo_q   <= 1'b0;
      oe_q     <= 1'b0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      bank_q   <= '{default: '0};
      flush_q  <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      cipo_q   <= cipo_d;
      oe_q     <= oe_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      bank_q   <= bank_d;
      flush_q  <= flush_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs[k*DATA_W +: DATA_W] = bank_q[k];
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = oe_q;
  assign wr_strobe   = strobe_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Scoreboard bench: default instance plus a 16-bit x 8 register instance on shared sclk/copi.
module tb_spi_regfile_peripheral;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs0 = 1'b1;
  logic ncs1 = 1'b1;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_regfile_peripheral_if if0 ();
  spi_regfile_peripheral_if if1 ();

  assign if0.sclk = sclk;
  assign if0.ncs  = ncs0;
  assign if0.copi = copi;
  assign if1.sclk = sclk;
  assign if1.ncs  = ncs1;
  assign if1.copi = copi;

  logic [39:0]  regs0;
  logic [4:0]   strb0;
  logic         err0;
  logic [127:0] regs1;
  logic [7:0]   strb1;
  logic         err1;

  spi_regfile_peripheral dut0 (
    .clk(clk), .rst_n(rst_n), .spi(if0.slave),
    .regs(regs0), .wr_strobe(strb0), .frame_err(err0)
  );

  spi_regfile_peripheral #(.ADDR_W(7), .DATA_W(16), .NUM_REGS(8), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(if1.slave),
    .regs(regs1), .wr_strobe(strb1), .frame_err(err1)
  );

  typedef struct {
    logic [15:0] mask;
    int          idx;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t     q_wr0[$];
  wr_exp_t     q_wr1[$];
  int          q_err0[$];
  int          q_err1[$];
  logic [15:0] q_rd_exp[$];
  logic [15:0] q_rd_act[$];

  logic [39:0]  m0 = '0;
  logic [127:0] m1 = '0;
  int unsigned  rise_cyc0 = 0;
  int unsigned  rise_cyc1 = 0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_oe(input int sel);
    return (sel != 0) ? if1.cipo_oe : if0.cipo_oe;
  endfunction

  function automatic logic get_cipo(input int sel);
    return (sel != 0) ? if1.cipo : if0.cipo;
  endfunction

  task automatic set_ncs(input int sel, input logic v);
    if (sel != 0) ncs1 = v;
    else          ncs0 = v;
  endtask

  // Mode-0 controller: copi changes with sclk low, cipo sampled at each sclk rise.
  task automatic xfer(input int sel, input int nbits, input logic [31:0] frm,
                      input bit do_fall, input bit do_rise, output logic [31:0] rx);
    rx = '0;
    if (do_fall) begin
      chk($sformatf("dut%0d cipo_oe before select", sel), 128'(get_oe(sel)), 128'(0));
      set_ncs(sel, 1'b0);
      step(HALF);
      chk($sformatf("dut%0d cipo_oe while selected", sel), 128'(get_oe(sel)), 128'(1));
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frm[i];
      step(HALF);
      sclk = 1'b1;
      rx = {rx[30:0], get_cipo(sel)};
      step(HALF);
      sclk = 1'b0;
    end
    step(HALF);
    if (do_rise) begin
      set_ncs(sel, 1'b1);
      if (sel != 0) rise_cyc1 = cyc;
      else          rise_cyc0 = cyc;
      step(2 * HALF);
      chk($sformatf("dut%0d cipo_oe after deselect", sel), 128'(get_oe(sel)), 128'(0));
    end
  endtask

  task automatic frame(input int sel, input int nbits, input logic [31:0] frm);
    logic [31:0] rx;
    xfer(sel, nbits, frm, 1'b1, 1'b1, rx);
  endtask

  task automatic read_frame(input int sel, input int nbits, input logic [31:0] frm,
                            input logic [15:0] exp);
    logic [31:0] rx;
    q_rd_exp.push_back(exp);
    xfer(sel, nbits, frm, 1'b1, 1'b1, rx);
    q_rd_act.push_back((sel != 0) ? rx[15:0] : {8'h00, rx[7:0]});
  endtask

  task automatic exp_wr(input int sel, input logic [15:0] mask, input int idx, input logic [15:0] data);
    wr_exp_t e;
    e.mask = mask;
    e.idx  = idx;
    e.data = data;
    if (sel != 0) q_wr1.push_back(e);
    else          q_wr0.push_back(e);
  endtask

  task automatic settle();
    step(6);
    chk("dut0 register bank", 128'(regs0), 128'(m0));
    chk("dut1 register bank", regs1, m1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dut0 outputs"}, 128'({regs0, strb0, err0, if0.cipo, if0.cipo_oe}), 128'(0));
    chk({tag, " dut1 regs"}, regs1, 128'(0));
    chk({tag, " dut1 other outputs"}, 128'({strb1, err1, if1.cipo, if1.cipo_oe}), 128'(0));
  endtask

  // Pops an expectation whenever a DUT raises a strobe, an error, or a read completes.
  task automatic monitor();
    wr_exp_t     e;
    logic [15:0] a;
    int          tag;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (strb0 != '0) begin
          if (q_wr0.size() == 0) chk("dut0 unexpected wr_strobe", 128'(strb0), 128'(0));
          else begin
            e = q_wr0.pop_front();
            chk("dut0 wr_strobe", 128'(strb0), 128'(e.mask));
            chk("dut0 written reg", 128'(regs0[e.idx*8 +: 8]), 128'(e.data));
            chk("dut0 commit latency", 128'(cyc - rise_cyc0), 128'(3));
          end
        end
        if (strb1 != '0) begin
          if (q_wr1.size() == 0) chk("dut1 unexpected wr_strobe", 128'(strb1), 128'(0));
          else begin
            e = q_wr1.pop_front();
            chk("dut1 wr_strobe", 128'(strb1), 128'(e.mask));
            chk("dut1 written reg", 128'(regs1[e.idx*16 +: 16]), 128'(e.data));
            chk("dut1 commit latency", 128'(cyc - rise_cyc1), 128'(3));
          end
        end
        if (err0) begin
          if (q_err0.size() == 0) chk("dut0 unexpected frame_err", 128'(err0), 128'(0));
          else begin
            tag = q_err0.pop_front();
            chk($sformatf("dut0 frame_err latency #%0d", tag), 128'(cyc - rise_cyc0), 128'(3));
          end
        end
        if (err1) begin
          if (q_err1.size() == 0) chk("dut1 unexpected frame_err", 128'(err1), 128'(0));
          else begin
            tag = q_err1.pop_front();
            chk($sformatf("dut1 frame_err latency #%0d", tag), 128'(cyc - rise_cyc1), 128'(3));
          end
        end
        if (q_rd_act.size() != 0) begin
          a = q_rd_act.pop_front();
          if (q_rd_exp.size() == 0) chk("read expectation queue depth", 128'(q_rd_exp.size()), 128'(1));
          else chk("read data on cipo", 128'(a), 128'(q_rd_exp.pop_front()));
        end
      end
    end
  endtask

  task automatic run();
    logic [31:0] rx;
    step(5);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step(10);
    chk_reset_outputs("post-reset idle");

    exp_wr(0, 16'h0001, 0, 16'h0001); m0[7:0] = 8'h01;
    frame(0, 16, 32'h0000_8001);
    settle();
    exp_wr(0, 16'h0010, 4, 16'h00A5); m0[39:32] = 8'hA5;
    frame(0, 16, 32'h0000_84A5);
    settle();

    read_frame(0, 16, 32'h0000_0400, 16'h00A5);
    settle();
    read_frame(0, 16, 32'h0000_0000, 16'h0001);
    settle();

    // Out-of-range write is dropped silently; out-of-range read returns zero.
    frame(0, 16, 32'h0000_FFFF);
    settle();
    read_frame(0, 16, 32'h0000_1000, 16'h0000);
    settle();

    q_err0.push_back(1);
    frame(0, 10, 32'h0000_0205);
    settle();
    q_err0.push_back(2);
    frame(0, 17, 32'h0001_02AB);
    settle();

    frame(0, 0, 32'h0);
    settle();

    // Reset in the middle of a frame, released while ncs is still low.
    xfer(0, 12, 32'h0000_0823, 1'b1, 1'b0, rx);
    rst_n = 1'b0;
    m0 = '0;
    m1 = '0;
    step(4);
    chk_reset_outputs("mid-frame reset");
    rst_n = 1'b1;
    step(4);
    xfer(0, 4, 32'h0000_000C, 1'b0, 1'b1, rx);
    settle();
    exp_wr(0, 16'h0004, 2, 16'h003C); m0[23:16] = 8'h3C;
    frame(0, 16, 32'h0000_823C);
    settle();

    exp_wr(1, 16'h0080, 7, 16'hBEEF); m1[127:112] = 16'hBEEF;
    frame(1, 24, 32'h0087_BEEF);
    settle();
    read_frame(1, 24, 32'h0007_0000, 16'hBEEF);
    settle();

    step(20);
    chk("dut0 pending writes", 128'(q_wr0.size()), 128'(0));
    chk("dut1 pending writes", 128'(q_wr1.size()), 128'(0));
    chk("dut0 pending frame errors", 128'(q_err0.size()), 128'(0));
    chk("pending reads", 128'(q_rd_exp.size() + q_rd_act.size()), 128'(0));
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral exposing a bank of configurable-width control registers to an external controller, with both write and read-back support. All SPI pins are oversampled in the fast `clk` domain, so the block is a drop-in successor for the write-only peripheral that feeds the output-enable and PWM configuration registers. New relative to that peripheral:

- configurable register count and width;
- CIPO read path;
- per-register write strobes;
- frame-error reporting.

## Interface
Parameters:
- `ADDR_W`, default 7: address field width in bits.
- `DATA_W`, default 8: data field and register width.
- `NUM_REGS`, default 5: number of implemented registers, at addresses 0..`NUM_REGS`-1. Must be ≤ 2^`ADDR_W`.
- `SYNC_STAGES`, default 2: synchroniser depth for the pin inputs. Must be ≥ 2.

Ports:
- `clk`  in  1  fast system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock (asynchronous to `clk`).
- `ncs`  in  1  SPI chip select, active-low.
- `copi`  in  1  controller-out data.
- `cipo`  out  1  peripheral-out data.
- `cipo_oe`  out  1  pad output enable for `cipo`.
- `regs`  out  `NUM_REGS`*`DATA_W`  flattened register bank; register k occupies bits [k*`DATA_W` +: `DATA_W`].
- `wr_strobe`  out  `NUM_REGS`  one-`clk` pulse on the bit of each register written.
- `frame_err`  out  1  one-`clk` pulse on each malformed frame.

## Operation
Frame format:
- Frame length is `FRAME` = 1+`ADDR_W`+`DATA_W` bits, MSB-first.
- Fields in order: R/W bit (1 = write, 0 = read), then address, then data.
- `copi` is sampled on detected `sclk` rising edges.
- `cipo` changes on detected `sclk` falling edges.

Synchronisation:
- `sclk`, `ncs` and `copi` each pass through `SYNC_STAGES` flops.
- Edges are detected from the last two stages.
- Reset value of the `ncs` synchroniser is all ones.

FSM states:
- IDLE: `ncs` high.
- CMD: collecting the R/W bit and address.
- DATA: collecting write data, or shifting out read data.
- FULL: exactly `FRAME` bits received.
- OVER: more than `FRAME` bits received.

FSM transitions:
- IDLE→CMD on detected `ncs` fall. This clears the bit counter, shift registers and the latched address.
- CMD→DATA after sampling the last address bit.
- DATA→FULL on the `FRAME`-th sampled bit.
- FULL→OVER on any further rising edge.
- Any state→IDLE on detected `ncs` rise.
- A detected `ncs` fall while not in IDLE restarts at CMD.

Write commit (on `ncs` rise):
- Commits only when leaving FULL with R/W=1 and address < `NUM_REGS`.
- Loads the addressed register and pulses its `wr_strobe` bit in the same cycle.
- An out-of-range address is silently dropped: no strobe, no error.
- Partial frames never modify registers.

Read:
- On the CMD→DATA transition with R/W=0, the addressed register is loaded into the output shifter and its MSB is driven onto `cipo` in that cycle.
- Each subsequent detected `sclk` fall shifts left, filling with 0.
- An out-of-range address reads as all zeros.
- Read frames never modify registers or pulse strobes.

Output pins:
- `cipo_oe` = synchronised `ncs` low.
- `cipo` = 0 whenever `cipo_oe` is low or the frame is a write.

Frame errors:
- `frame_err` pulses on `ncs` rise when leaving CMD or DATA with at least one bit sampled, or when leaving OVER.
- A zero-bit select (`ncs` low then high with no `sclk` edge) is not an error.

Reset:
- All registers, `regs`, `wr_strobe`, `frame_err`, `cipo` and `cipo_oe` reset to 0.
- FSM resets to IDLE.
- Reset asserted mid-frame discards the frame. The frame in progress when reset is released is ignored until the next `ncs` fall.

## Timing
- Pin-to-detect latency is `SYNC_STAGES`+1 `clk` cycles.
- Commit latency: `regs` and `wr_strobe` update exactly `SYNC_STAGES`+1 `clk` edges after `ncs` rises at the pin.
- `frame_err` has the same latency as a commit.
- Read data for bit i is valid on `cipo` no later than `SYNC_STAGES`+2 `clk` after the preceding `sclk` fall.
- Legal SPI timing requires `sclk` high and low phases each ≥ `SYNC_STAGES`+3 `clk` periods, and `ncs` setup/hold to `sclk` ≥ the same. Behaviour outside these limits is undefined but must not lock up: the next `ncs` fall recovers.
- Simultaneous detected `ncs` rise and `sclk` edge: `ncs` wins and the edge is ignored.
- The bit counter is ⌈log2(`FRAME`+1)⌉ bits wide. It saturates at `FRAME`+1, so the OVER state holds and the counter never wraps.

## Structure
Package `spi_regfile_pkg` holds:
- FSM state enum (IDLE, CMD, DATA, FULL, OVER);
- constant function `frame_bits(addr_w, data_w)`;
- R/W encoding constants `SPI_WR`=1 and `SPI_RD`=0.

Sub-module `spi_pin_sync` (parameter `STAGES`; outputs level, rise, fall) is instantiated three times: `sclk`, `ncs` (reset-high variant via a parameter), and `copi` (level only).

## Test plan
- Write 0x01 to addr 0, then 0xA5 to addr 4 (defaults) → `regs[7:0]`=0x01, `regs[39:32]`=0xA5. `wr_strobe` pulses 0x01 then 0x10, each exactly one cycle, at `ncs` rise + 3 clk.
- Read addr 4 after the previous write → `cipo` shifts out 1010_0101 in data bits 9..16; `cipo_oe` high only during `ncs` low; `regs` unchanged.
- Write addr 0x7F, data 0xFF → no strobe, no `frame_err`, bank unchanged. Read addr 0x10 → 0x00 shifted out.
- Abort a write after 10 bits, then send a 17-bit write → `frame_err` pulses once per frame; registers unchanged.
- Assert `rst_n` low mid-frame after 12 bits, release it, then send a full write of 0x3C to addr 2 → all outputs 0 during reset; only 0x3C lands in `regs[23:16]`.
- Instance with `DATA_W`=16, `NUM_REGS`=8: write 0xBEEF to addr 7, then read it back → `regs[127:112]`=0xBEEF and the same 16 bits appear on `cipo`.
